// File: rtl/fm_cmd_seq_pkg.sv
// Shared definitions for the FM synth command sequencer: state encoding,
// queue entry layout and field widths.
package fm_cmd_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DLY_W  = 16;

  // Sequencer states; the encoding is fixed so debug taps stay readable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DELAY = 2'd2
  } seq_state_e;

  // One queued command: 1 + 8 + 32 = 41 bits.
  typedef struct packed {
    logic              delay;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_entry_t;

  // A delay command carries its sample count in the low data bits.
  function automatic logic [DLY_W-1:0] delay_count(cmd_entry_t e);
    return e.data[DLY_W-1:0];
  endfunction

endpackage

// File: rtl/fm_cmd_seq_if.sv
// Command channel (requester -> sequencer) and synth register bus
// (sequencer -> synth).
interface fm_cmd_if;
  import fm_cmd_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_delay;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, cmd_delay, cmd_addr, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_delay, cmd_addr, cmd_data, output cmd_ready);
endinterface

interface fm_bus_if;
  import fm_cmd_seq_pkg::*;

  logic [ADDR_W-1:0] fm_addr;
  logic [DATA_W-1:0] fm_wrdata;
  logic              fm_wren;
  logic              fm_wait;

  modport master (output fm_addr, fm_wrdata, fm_wren, input fm_wait);
  modport slave  (input fm_addr, fm_wrdata, fm_wren, output fm_wait);
endinterface

// File: rtl/fm_cmd_fifo.sv
// Single-clock command FIFO with a registered show-ahead head: rd_data is a
// flop that always holds the oldest entry whenever level != 0.
module fm_cmd_fifo
  import fm_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  cmd_entry_t               wr_data,
  input  logic                     pop,
  output cmd_entry_t               rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  cmd_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  cmd_entry_t       rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Pointer/level update and next head selection, with write-through bypass
  // when the entry being written becomes the new head.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (push_ok && (wr_ptr_q == rd_ptr_d)) rd_data_d = wr_data;
      else                                   rd_data_d = mem_q[rd_ptr_d];
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of evaluation order.
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Entry storage write port.
  // NOTE: storage has no reset; pointers and level define which entries are
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/fm_cmd_seq.sv
// FM synth command sequencer: queues register writes and sample-count
// delays, then replays them in order onto the synth register bus.
module fm_cmd_seq
  import fm_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fm_cmd_if.slave                cmd,
  fm_bus_if.master               bus,
  input  logic                   flush,
  input  logic                   sample_tick,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  seq_state_e        state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  cmd_entry_t wr_entry;
  cmd_entry_t head;
  logic       fifo_full, fifo_empty;
  logic       pop;

  assign wr_entry      = '{delay: cmd.cmd_delay, addr: cmd.cmd_addr, data: cmd.cmd_data};
  assign cmd.cmd_ready = !fifo_full;

  fm_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (cmd.cmd_valid),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state logic; a write stays at the head of the queue until the synth
  // accepts it, so a flush mid-stall simply discards it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.delay) begin
              pop = 1'b1;
              if (delay_count(head) != '0) begin
                cnt_d   = delay_count(head);
                state_d = DELAY;
              end
            end else begin
              addr_d  = head.addr;
              data_d  = head.data;
              state_d = ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.fm_wait) begin
            pop     = 1'b1;
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (sample_tick) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DLY_W'(1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state, delay counter and registered bus address/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.fm_wren   = (state_q == ISSUE);
  assign bus.fm_addr   = addr_q;
  assign bus.fm_wrdata = data_q;
  assign busy          = (state_q != IDLE) || (level != '0);

endmodule

// File: tb/tb_fm_cmd_seq.sv
// Directed self-checking bench for fm_cmd_seq.
module tb_fm_cmd_seq;
  import fm_cmd_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             sample_tick = 1'b0;
  logic [LVL_W-1:0] level;
  logic             busy;

  fm_cmd_if cmd_if ();
  fm_bus_if bus_if ();

  fm_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd_if),
    .bus         (bus_if),
    .flush       (flush),
    .sample_tick (sample_tick),
    .level       (level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bus log: every completed write, plus strobe cycle count and stability.
  logic [39:0] issued[$];
  int          wren_cycles = 0;
  int          unstable = 0;
  logic        prev_stall = 1'b0;
  logic [39:0] prev_bus = '0;

  always @(negedge clk) begin
    if (bus_if.fm_wren) begin
      wren_cycles++;
      if (prev_stall && ({bus_if.fm_addr, bus_if.fm_wrdata} !== prev_bus)) unstable++;
      if (!bus_if.fm_wait) issued.push_back({bus_if.fm_addr, bus_if.fm_wrdata});
    end
    prev_stall = bus_if.fm_wren && bus_if.fm_wait;
    prev_bus   = {bus_if.fm_addr, bus_if.fm_wrdata};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] log_at(input int i);
    if (i < issued.size()) return issued[i];
    return 'x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dly, input logic [7:0] a, input logic [31:0] d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_delay = dly;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_data  = d;
    step(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      step(1);
      n++;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic clear_log();
    issued.delete();
    wren_cycles = 0;
    unstable    = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_delay = 1'b0;
    cmd_if.cmd_addr  = '0;
    cmd_if.cmd_data  = '0;
    bus_if.fm_wait   = 1'b0;

    // Reset state
    step(3);
    reset_n = 1'b1;
    step(1);
    check("rst_ready", 64'(cmd_if.cmd_ready), 64'(1));
    check("rst_busy",  64'(busy), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_wren",  64'(bus_if.fm_wren), 64'(0));
    check("rst_addr",  64'(bus_if.fm_addr), 64'(0));
    check("rst_data",  64'(bus_if.fm_wrdata), 64'(0));

    // Single unstalled write
    clear_log();
    push(1'b0, 8'h02, 32'h0000_0003);
    check("w1_level1", 64'(level), 64'(1));
    wait_idle("w1", 20);
    check("w1_count", 64'(issued.size()), 64'(1));
    check("w1_entry", 64'(log_at(0)), 64'({8'h02, 32'h3}));
    check("w1_wren_cycles", 64'(wren_cycles), 64'(1));
    check("w1_level0", 64'(level), 64'(0));

    // Write stalled for 500 cycles
    clear_log();
    bus_if.fm_wait = 1'b1;
    push(1'b0, 8'h10, 32'hDEAD_BEEF);
    for (int n = 0; n < 10 && !bus_if.fm_wren; n++) step(1);
    check("st_wren_up", 64'(bus_if.fm_wren), 64'(1));
    step(500);
    check("st_count_mid", 64'(issued.size()), 64'(0));
    bus_if.fm_wait = 1'b0;
    step(1);
    check("st_wren_down", 64'(bus_if.fm_wren), 64'(0));
    check("st_wren_cycles", 64'(wren_cycles), 64'(501));
    check("st_unstable", 64'(unstable), 64'(0));
    check("st_count", 64'(issued.size()), 64'(1));
    check("st_entry", 64'(log_at(0)), 64'({8'h10, 32'hDEAD_BEEF}));
    check("st_busy", 64'(busy), 64'(0));

    // Write A, delay 3 ticks, write B
    clear_log();
    push(1'b0, 8'h20, 32'h0000_000A);
    push(1'b1, 8'h00, 32'h0000_0003);
    push(1'b0, 8'h21, 32'h0000_000B);
    for (int k = 1; k <= 3; k++) begin
      step(505);
      check($sformatf("dl_pre_tick%0d", k), 64'(issued.size()), 64'(1));
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
    end
    for (int n = 0; n < 6 && issued.size() < 2; n++) step(1);
    check("dl_count", 64'(issued.size()), 64'(2));
    check("dl_a", 64'(log_at(0)), 64'({8'h20, 32'hA}));
    check("dl_b", 64'(log_at(1)), 64'({8'h21, 32'hB}));
    wait_idle("dl", 10);

    // Zero-count delay passes straight through
    clear_log();
    push(1'b1, 8'h00, 32'h0000_0000);
    push(1'b0, 8'h30, 32'h0000_0030);
    wait_idle("d0", 20);
    check("d0_count", 64'(issued.size()), 64'(1));
    check("d0_entry", 64'(log_at(0)), 64'({8'h30, 32'h30}));

    // Fill to DEPTH under stall, extra push dropped, drain in order
    clear_log();
    bus_if.fm_wait = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(1'b0, 8'(8'h40 + i), 32'(32'h1000 + i));
    check("fl_level_full", 64'(level), 64'(DEPTH));
    check("fl_ready_low", 64'(cmd_if.cmd_ready), 64'(0));
    push(1'b0, 8'hEE, 32'h0000_00EE);
    check("fl_level_drop", 64'(level), 64'(DEPTH));
    bus_if.fm_wait = 1'b0;
    wait_idle("fl", 100);
    check("fl_count", 64'(issued.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("fl_entry%0d", i), 64'(log_at(i)), 64'({8'(8'h40 + i), 32'(32'h1000 + i)}));

    // Flush during stalled write, push in the flush cycle dropped
    clear_log();
    bus_if.fm_wait = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h60 + i), 32'(i));
    check("fx_level5", 64'(level), 64'(5));
    check("fx_wren", 64'(bus_if.fm_wren), 64'(1));
    flush = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_delay = 1'b0;
    cmd_if.cmd_addr  = 8'h77;
    cmd_if.cmd_data  = 32'h77;
    step(1);
    flush = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    check("fx_wren0", 64'(bus_if.fm_wren), 64'(0));
    check("fx_level0", 64'(level), 64'(0));
    check("fx_busy0", 64'(busy), 64'(0));
    check("fx_none", 64'(issued.size()), 64'(0));
    bus_if.fm_wait = 1'b0;
    push(1'b0, 8'h55, 32'h1234_5678);
    wait_idle("fx", 20);
    check("fx_after_count", 64'(issued.size()), 64'(1));
    check("fx_after_entry", 64'(log_at(0)), 64'({8'h55, 32'h1234_5678}));

    // Reset during a 100-tick delay with a write queued behind it
    clear_log();
    push(1'b1, 8'h00, 32'd100);
    push(1'b0, 8'h99, 32'h99);
    step(2);
    check("rd_level_pre", 64'(level), 64'(1));
    check("rd_busy_pre", 64'(busy), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rd_wren", 64'(bus_if.fm_wren), 64'(0));
    check("rd_level", 64'(level), 64'(0));
    check("rd_busy", 64'(busy), 64'(0));
    step(2);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(10);
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
    end
    step(10);
    check("rd_none", 64'(issued.size()), 64'(0));
    check("rd_idle", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
